text_cell_fetch: RTL and testbench

- Display-side consumer of the VRAM readout port, sitting between the VGA timing generator and the pixel generator.
- Holds `readoutAddr` for each text cell and samples the character byte, then the attribute byte, from `readoutData`.
- Presents one character/attribute pair per 8-pixel cell, prefetched one cell ahead of display.
- Text layout: 80x30 cells of 8x16 pixels on 640x480. Cell c = row*COLS+col; its char byte is at BASE_ADDR+2c and its attr byte at BASE_ADDR+2c+1.

---
 rtl/text_cell_fetch.sv | 112 +++++++++++
 tb/tb_text_cell_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/text_cell_fetch.sv
// text_cell_fetch: reads each text cell's char and attr bytes from VRAM one cell ahead of display
// and presents them, with the glyph row, for the 8 clocks of that cell.
module text_cell_fetch #(
  parameter int H_TOTAL = 800,
  parameter int H_VISIBLE = 640,
  parameter int V_TOTAL = 525,
  parameter int V_VISIBLE = 480,
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter logic [12:0] BASE_ADDR = 13'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [12:0] readoutAddr,
  input  logic [7:0]  readoutData,
  output logic [7:0]  charCode,
  output logic [7:0]  attrData,
  output logic [3:0]  glyphRow,
  output logic        cellStart
);
  localparam int VIS_W = H_VISIBLE < COLS * 8 ? H_VISIBLE : COLS * 8;
  localparam int VIS_H = V_VISIBLE < ROWS * 16 ? V_VISIBLE : ROWS * 16;
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] PRE_H = 10'(H_TOTAL - 8);
  localparam logic [9:0] LAST_H = 10'(VIS_W - 8);
  localparam logic [9:0] VIS_L = 10'(VIS_H);

  typedef struct packed {
    logic       act;
    logic [9:0] line;
    logic [6:0] col;
  } win_t;

  // The last 8 clocks of a line fetch cell 0 of the following line.
  function automatic win_t win_of(input logic [9:0] h, input logic [9:0] v);
    win_t w;
    logic pre;
    pre = h >= PRE_H;
    w.line = pre ? (v == VT_M1 ? 10'd0 : v + 10'd1) : v;
    w.col = pre ? 7'd0 : h[9:3] + 7'd1;
    w.act = (pre || h < LAST_H) && w.line < VIS_L;
    return w;
  endfunction

  function automatic logic [12:0] char_addr(input logic [5:0] row, input logic [6:0] col);
    logic [11:0] idx;
    idx = {row, 6'd0} + {2'd0, row, 4'd0} + {5'd0, col};
    return BASE_ADDR + {idx, 1'b0};
  endfunction

  logic [9:0]  hn, vn;
  win_t        nxt;
  logic        load_char, grab_char, emit;
  logic [12:0] addr_q, addr_d;
  logic        fetch_q, fetch_d;
  logic [7:0]  stage_q, stage_d;
  logic [3:0]  pend_row_q, pend_row_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic [3:0]  row_q, row_d;
  logic        start_q, start_d;

  assign hn = hcount == HT_M1 ? 10'd0 : hcount + 10'd1;
  assign vn = hcount != HT_M1 ? vcount : vcount == VT_M1 ? 10'd0 : vcount + 10'd1;
  assign nxt = win_of(hn, vn);

  // fetch_q marks a window whose char address was loaded out of reset, so no partial cell is emitted.
  always_comb begin
    load_char = nxt.act && hn[2:0] == 3'd0;
    grab_char = fetch_q && hcount[2:0] == 3'd3;
    emit = fetch_q && hcount[2:0] == 3'd7;
    addr_d = load_char ? char_addr(nxt.line[9:4], nxt.col) : grab_char ? addr_q + 13'd1 : addr_q;
    fetch_d = load_char ? 1'b1 : emit ? 1'b0 : fetch_q;
    pend_row_d = load_char ? nxt.line[3:0] : pend_row_q;
    stage_d = grab_char ? readoutData : stage_q;
    char_d = emit ? stage_q : char_q;
    attr_d = emit ? readoutData : attr_q;
    row_d = emit ? pend_row_q : row_q;
    start_d = emit;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q <= '0;
      fetch_q <= 1'b0;
      pend_row_q <= '0;
      stage_q <= '0;
      char_q <= '0;
      attr_q <= '0;
      row_q <= '0;
      start_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      fetch_q <= fetch_d;
      pend_row_q <= pend_row_d;
      stage_q <= stage_d;
      char_q <= char_d;
      attr_q <= attr_d;
      row_q <= row_d;
      start_q <= start_d;
    end
  end

  assign readoutAddr = addr_q;
  assign charCode = char_q;
  assign attrData = attr_q;
  assign glyphRow = row_q;
  assign cellStart = start_q;
endmodule

// File: tb/tb_text_cell_fetch.sv
// tb_text_cell_fetch: drives timing counters and a VRAM model with varied read latency,
// and scoreboards every cell against a cell-arithmetic reference.
module tb_text_cell_fetch;
  localparam int BASE = 0;
  logic        clk = 1'b0;
  logic        nrst;
  logic [9:0]  hcount, vcount;
  logic [12:0] readoutAddr;
  logic [7:0]  readoutData, charCode, attrData;
  logic [3:0]  glyphRow;
  logic        cellStart;

  always #5 clk = ~clk;

  text_cell_fetch dut (
    .clk(clk), .nrst(nrst), .hcount(hcount), .vcount(vcount),
    .readoutAddr(readoutAddr), .readoutData(readoutData),
    .charCode(charCode), .attrData(attrData), .glyphRow(glyphRow), .cellStart(cellStart)
  );

  typedef struct {
    int h;
    int v;
    logic [7:0] ch;
    logic [7:0] at;
    logic [3:0] row;
  } exp_t;

  exp_t q[$];
  logic [7:0] mem [8192];
  int h, v, ok_cnt, mode, cycles, pushed, seen, chk_cnt, pass_cnt, jump_v;
  bit jump_pending, done, phase;
  logic [12:0] a_prev, exp_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (v=%0d h=%0d)", name, act, exp, v, h);
  endtask

  function automatic void fill_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
  endfunction

  task automatic tick(input logic r);
    int k, l, p, c;
    @(posedge clk);
    #1;
    cycles++;
    if (cycles > 90000) begin
      $display("FAIL cycle_budget: got %0d cycles, expected at most 90000", cycles);
      $fatal(1);
    end
    ok_cnt = nrst ? ok_cnt + 1 : 0;
    h = h == 799 ? 0 : h + 1;
    if (h == 0) begin
      v = v == 524 ? 0 : v + 1;
      mode = v == 1 ? 2 : int'($urandom_range(0, 3));
    end
    if (jump_pending && h == 700) begin
      v = jump_v;
      jump_pending = 0;
      fill_mem();
    end
    hcount = 10'(h);
    vcount = 10'(v);
    nrst = r;
    case (mode)
      0: readoutData = mem[readoutAddr];
      1: readoutData = mem[a_prev];
      2: readoutData = readoutAddr[0] ? mem[a_prev] : mem[readoutAddr];
      default: begin
        if (phase) readoutData = mem[readoutAddr];
        phase = ~phase;
      end
    endcase
    a_prev = readoutAddr;
    p = h % 8;
    if (!nrst) exp_addr = '0;
    else begin
      if (h >= 792) begin k = 0; l = (v + 1) % 525; end
      else if (h < 632) begin k = h / 8 + 1; l = v; end
      else begin k = -1; l = 0; end
      if (k >= 0 && l < 480 && ok_cnt >= p + 1)
        exp_addr = 13'((BASE + 2 * ((l / 16) * 80 + k) + (p >= 4 ? 1 : 0)) % 8192);
    end
    if (nrst && p == 0 && h < 640 && v < 480 && ok_cnt >= 9) begin
      c = (BASE + 2 * ((v / 16) * 80 + h / 8)) % 8192;
      q.push_back('{h, v, mem[c], mem[(c + 1) % 8192], 4'(v % 16)});
      pushed++;
    end
  endtask

  task automatic run_to(input int tv, input int th);
    while (!(v == tv && h == th)) tick(1'b1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] last_ch, last_at;
    logic [3:0] last_row;
    bit exp_s;
    last_ch = '0; last_at = '0; last_row = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!nrst) begin
        q.delete();
        last_ch = '0; last_at = '0; last_row = '0;
        check("reset_outputs", {readoutAddr, charCode, attrData, glyphRow, cellStart}, 64'd0);
        continue;
      end
      check("readoutAddr", readoutAddr, exp_addr);
      exp_s = q.size() > 0 && q[0].h == h && q[0].v == v;
      check("cellStart", cellStart, exp_s);
      if (cellStart) seen++;
      if (exp_s) begin
        e = q.pop_front();
        last_ch = e.ch; last_at = e.at; last_row = e.row;
      end
      check(exp_s ? "cell_data" : "cell_hold", {charCode, attrData, glyphRow}, {last_ch, last_at, last_row});
    end
  end

  initial begin
    nrst = 1'b1;
    h = 770; v = 524; mode = 2;
    hcount = 10'(h); vcount = 10'(v);
    readoutData = '0; a_prev = '0; exp_addr = '0;
    fill_mem();
    mem[0] = 8'h41;
    mem[1] = 8'h1F;
    #2 nrst = 1'b0;
    while (h != 779) tick(1'b0);
    tick(1'b1);
    run_to(10, 299);
    repeat (3) tick(1'b0);
    run_to(40, 650);
    jump_v = 476; jump_pending = 1;
    run_to(483, 650);
    jump_v = 523; jump_pending = 1;
    run_to(2, 650);
    for (int s = 0; s < 3; s++) begin
      jump_v = int'($urandom_range(1, 470));
      jump_pending = 1;
      repeat (1600 + int'($urandom_range(0, 799))) tick(1'b1);
      repeat (int'($urandom_range(1, 5))) tick(1'b0);
      repeat (2400) tick(1'b1);
    end
    done = 1;
    @(negedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    check("pulse_count", 64'(seen), 64'(pushed));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
